// File: rtl/ram_ctrl.sv
// Command-driven initiator for the 8x16 RAM: single/burst read and write
// commands over valid/ready, streaming data with backpressure and wrapping addresses.
module ram_ctrl #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic          ram_en,
  input  logic [DW-1:0] ram_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    RDOUT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  // Next-state and datapath update for the burst sequencer
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          ptr_d   = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_wr ? WR : RD;
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        if (wr_valid) begin
          ptr_d = ptr_q + AW'(1);
          if (cnt_q == {AW{1'b0}}) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - AW'(1);
          end
        end else begin
          state_d = WR;
        end
      end
      RD: begin
        // The RAM read port is combinational, so capture it the same cycle
        rd_data_d = ram_q;
        state_d   = RDOUT;
      end
      RDOUT: begin
        if (rd_ready) begin
          ptr_d = ptr_q + AW'(1);
          if (cnt_q == {AW{1'b0}}) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q - AW'(1);
            state_d = RD;
          end
        end else begin
          state_d = RDOUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= {AW{1'b0}};
      cnt_q     <= {AW{1'b0}};
      rd_data_q <= {DW{1'b0}};
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Handshake and RAM-side outputs decoded from the registered state
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    wr_ready  = (state_q == WR);
    rd_valid  = (state_q == RDOUT);
    ram_a     = ptr_q;
    if (state_q == WR) begin
      ram_en = wr_valid;
      ram_d  = wr_data;
    end else begin
      ram_en = 1'b0;
      ram_d  = {DW{1'b0}};
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: behavioural RAM, expected-memory model,
// directed scenarios followed by randomized bursts with random stalls.
module tb_ram_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [2:0]  cmd_addr, cmd_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [15:0] rd_data;
  logic        busy;
  logic [2:0]  ram_a;
  logic [15:0] ram_d;
  logic        ram_en;
  logic [15:0] ram_q;

  logic [15:0] mem [8];
  logic [15:0] exp_mem [8];
  logic        mem_clr;
  logic        in_read;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          en_cnt  = 0;
  int          bad_en  = 0;

  always #5 clk = ~clk;

  ram_ctrl #(.DW(16), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .ram_a(ram_a), .ram_d(ram_d), .ram_en(ram_en), .ram_q(ram_q)
  );

  // Behavioural 8x16 RAM: synchronous write, combinational read
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'd0;
    end else if (ram_en) begin
      mem[ram_a] <= ram_d;
    end
  end
  assign ram_q = mem[ram_a];

  // Write-enable monitor: count writes, flag any write without wr_valid or during a read
  always @(posedge clk) begin
    if (rst_n && ram_en) begin
      en_cnt <= en_cnt + 1;
      if (!wr_valid || in_read) bad_en <= bad_en + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_wr_ready"},  32'(wr_ready),  32'd0);
    check({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
    check({tag, "_rd_data"},   32'(rd_data),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_ram_a"},     32'(ram_a),     32'd0);
    check({tag, "_ram_d"},     32'(ram_d),     32'd0);
    check({tag, "_ram_en"},    32'(ram_en),    32'd0);
  endtask

  // Present a command at a falling edge; returns at the falling edge after acceptance
  task automatic send_cmd(input logic wr, input logic [2:0] a, input logic [2:0] l);
    int n = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = l;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 32'(n < 50), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Write burst; beat valid follows vpat (cyclic) when use_pat, else random with stall_pct
  task automatic write_burst(input logic [2:0] a, input logic [2:0] l, input bit seq,
                             input logic [15:0] base, input bit use_pat,
                             input logic [7:0] vpat, input int stall_pct);
    int beat = 0;
    int cyc  = 0;
    logic v;
    logic [2:0] p;
    logic [15:0] d;
    send_cmd(1'b1, a, l);
    while (beat <= int'(l) && cyc < 200) begin
      v = use_pat ? vpat[cyc % 8] : (int'($urandom_range(99)) >= stall_pct);
      d = seq ? base + 16'(beat) : 16'($urandom);
      p = a + 3'(beat);
      wr_valid = v; wr_data = d;
      #1;
      check("wr_ready", 32'(wr_ready), 32'd1);
      check("wr_ram_en", 32'(ram_en), 32'(v));
      check("wr_ram_a", 32'(ram_a), 32'(p));
      check("wr_cmd_ready", 32'(cmd_ready), 32'd0);
      if (v) begin
        exp_mem[p] = d;
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    wr_valid = 1'b0;
    check("wr_beats_done", 32'(beat), 32'(int'(l) + 1));
    check("wr_end_busy", 32'(busy), 32'd0);
    check("wr_end_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  // Read beats after a read command was accepted; stall rd_ready on one beat
  task automatic read_beats(input logic [2:0] a, input logic [2:0] l,
                            input int stall_beat, input int stall_n);
    logic [2:0]  p;
    logic [15:0] e;
    in_read = 1'b1;
    for (int b = 0; b <= int'(l); b++) begin
      p = a + 3'(b);
      e = exp_mem[p];
      check("rd_fetch_valid", 32'(rd_valid), 32'd0);
      check("rd_fetch_busy", 32'(busy), 32'd1);
      check("rd_ram_a", 32'(ram_a), 32'(p));
      check("rd_ram_d", 32'(ram_d), 32'd0);
      @(negedge clk);
      rd_ready = 1'b0;
      check("rd_valid", 32'(rd_valid), 32'd1);
      check("rd_data", 32'(rd_data), 32'(e));
      if (b == stall_beat) begin
        repeat (stall_n) begin
          @(negedge clk);
          check("rd_hold_valid", 32'(rd_valid), 32'd1);
          check("rd_hold_data", 32'(rd_data), 32'(e));
        end
      end
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end
    in_read = 1'b0;
    check("rd_end_busy", 32'(busy), 32'd0);
    check("rd_end_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int en0;
    rst_n = 1'b0; mem_clr = 1'b1; in_read = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 3'd0; cmd_len = 3'd0;
    wr_valid = 1'b0; wr_data = 16'd0; rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) exp_mem[i] = 16'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1; mem_clr = 1'b0;
    @(negedge clk);

    // Single write then single read
    write_burst(3'd1, 3'd0, 1'b1, 16'd100, 1'b1, 8'hFF, 0);
    send_cmd(1'b0, 3'd1, 3'd0);
    read_beats(3'd1, 3'd0, 0, 0);

    // Wrapping burst 6,7,0,1
    write_burst(3'd6, 3'd3, 1'b1, 16'd10, 1'b1, 8'hFF, 0);
    check("wrap_mem6", 32'(mem[6]), 32'd10);
    check("wrap_mem7", 32'(mem[7]), 32'd11);
    check("wrap_mem0", 32'(mem[0]), 32'd12);
    check("wrap_mem1", 32'(mem[1]), 32'd13);
    send_cmd(1'b0, 3'd6, 3'd3);
    read_beats(3'd6, 3'd3, 0, 0);

    // wr_valid toggled 1,0,0,1,1 over a 3-beat burst
    en0 = en_cnt;
    write_burst(3'd3, 3'd2, 1'b1, 16'h0200, 1'b1, 8'b1111_1001, 0);
    check("toggle_write_count", 32'(en_cnt - en0), 32'd3);

    // Full-depth read with rd_ready low for 3 cycles on beat 2
    send_cmd(1'b0, 3'd0, 3'd7);
    read_beats(3'd0, 3'd7, 2, 3);

    // Second command held during a write burst
    send_cmd(1'b1, 3'd2, 3'd1);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 3'd2; cmd_len = 3'd1;
    for (int b = 0; b < 2; b++) begin
      wr_valid = 1'b1; wr_data = 16'h0A00 + 16'(b);
      #1;
      check("held_cmd_ready", 32'(cmd_ready), 32'd0);
      exp_mem[3'd2 + 3'(b)] = wr_data;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("second_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    read_beats(3'd2, 3'd1, 1, 1);

    // Randomized bursts
    for (int it = 0; it < 24; it++) begin
      logic [2:0] ra, rl;
      ra = 3'($urandom_range(7));
      rl = 3'($urandom_range(7));
      if ($urandom_range(1) == 0) begin
        write_burst(ra, rl, 1'b0, 16'd0, 1'b0, 8'h00, 30);
      end else begin
        send_cmd(1'b0, ra, rl);
        read_beats(ra, rl, int'($urandom_range(int'(rl))), int'($urandom_range(3)));
      end
    end

    // Ensure rd_data is non-zero before the mid-burst reset
    exp_mem[5] = 16'hBEEF;
    write_burst(3'd5, 3'd0, 1'b1, 16'hBEEF, 1'b1, 8'hFF, 0);
    send_cmd(1'b0, 3'd5, 3'd0);
    read_beats(3'd5, 3'd0, 0, 0);

    // Reset after 2 of 4 write beats
    send_cmd(1'b1, 3'd4, 3'd3);
    for (int b = 0; b < 2; b++) begin
      wr_valid = 1'b1; wr_data = 16'h5500 + 16'(b);
      exp_mem[3'd4 + 3'(b)] = wr_data;
      @(negedge clk);
    end
    wr_valid = 1'b1; wr_data = 16'hDEAD;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midburst_reset");
    @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b0;
    @(negedge clk);
    send_cmd(1'b0, 3'd0, 3'd7);
    read_beats(3'd0, 3'd7, int'($urandom_range(7)), 2);

    check("no_stray_ram_en", 32'(bad_en), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
